// File: rtl/mop_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mop_queue_pkg
// Brief    : Shared micro-op types and helpers for the decode-to-regread queue.
// Revision : 1.0 - initial release
// ============================================================================
package mop_queue_pkg;

    localparam int MOP_Q_MAX_CRACK = 3;

    // Opcodes strictly between M_JMIN and M_JMAX are control-transfer micro-ops.
    typedef enum logic [4:0] {
        M_NOP  = 5'd0,
        M_LD   = 5'd1,
        M_ADD  = 5'd2,
        M_SUB  = 5'd3,
        M_ST   = 5'd4,
        M_JMIN = 5'd5,
        M_JCC  = 5'd6,
        M_JMP  = 5'd7,
        M_JMAX = 5'd8
    } micro_opcode_t;

    typedef struct packed {
        micro_opcode_t opcode;
        logic [5:0]    dst;
        logic [5:0]    src1;
        logic [5:0]    src2;
        logic [15:0]   imm;
        logic [7:0]    seq;
    } micro_op_t;

    typedef micro_op_t mop_bundle_t [MOP_Q_MAX_CRACK];

    function automatic logic mop_is_branch(micro_opcode_t op);
        return (op > M_JMIN) && (op < M_JMAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mop_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : mop_queue_if
// Brief    : Enqueue/dequeue handshake bundle between decode, queue and regread.
// Revision : 1.0 - initial release
// ============================================================================
interface mop_queue_if
    import mop_queue_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int ENQ_WIDTH = MOP_Q_MAX_CRACK
);

    logic                               enq_valid;
    logic [$clog2(ENQ_WIDTH+1)-1:0]     enq_count;
    micro_op_t [ENQ_WIDTH-1:0]          enq_mops;
    logic                               enq_ready;
    logic                               deq_valid;
    logic                               deq_ready;
    micro_op_t                          deq_mop;
    logic [$clog2(DEPTH+1)-1:0]         occupancy;

    // master: decode + register-read side; slave: the queue itself
    modport master (
        output enq_valid, enq_count, enq_mops, deq_ready,
        input  enq_ready, deq_valid, deq_mop, occupancy
    );

    modport slave (
        input  enq_valid, enq_count, enq_mops, deq_ready,
        output enq_ready, deq_valid, deq_mop, occupancy
    );

endinterface
`default_nettype wire

// File: rtl/mop_queue.sv
`default_nettype none
// ============================================================================
// Module   : mop_queue
// Brief    : Multi-enqueue / single-dequeue micro-op FIFO with flush.
//            Optional statistics outputs enabled by MOP_QUEUE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mop_queue
    import mop_queue_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int ENQ_WIDTH = MOP_Q_MAX_CRACK
) (
    input  wire logic                       clk,
    input  wire logic                       reset_n,
    input  wire logic                       flush,
    mop_queue_if.slave                      q
`ifdef MOP_QUEUE_STATS_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]      stat_max_occ,
    output logic [31:0]                     stat_enq_stalls
`endif
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = $clog2(DEPTH+1);
    localparam int c_ECNT_W = $clog2(ENQ_WIDTH+1);

    micro_op_t            r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_enq_ready;
    logic                 w_enq_fire;
    logic                 w_deq_valid;
    logic                 w_pop;
    logic [c_CNT_W-1:0]   w_enq_add;

    assign w_enq_ready = (32'(DEPTH) - 32'(r_count)) >= 32'(ENQ_WIDTH);
    assign w_enq_fire  = q.enq_valid & w_enq_ready & ~flush;
    assign w_deq_valid = (r_count != '0) & ~flush;
    assign w_pop       = w_deq_valid & q.deq_ready;
    assign w_enq_add   = w_enq_fire ? c_CNT_W'(q.enq_count) : '0;

    assign q.enq_ready = w_enq_ready;
    assign q.deq_valid = w_deq_valid;
    assign q.deq_mop   = (r_count != '0) ? r_mem[r_head] : '0;
    assign q.occupancy = r_count;

    // Storage needs no reset: only slots between head and tail are ever read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (w_enq_fire && (c_ECNT_W'(i) < q.enq_count)) begin
                r_mem[r_tail + c_PTR_W'(i)] <= q.enq_mops[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + (w_enq_fire ? c_PTR_W'(q.enq_count) : '0);
            r_head  <= r_head + (w_pop ? c_PTR_W'(1) : '0);
            r_count <= r_count + w_enq_add - (w_pop ? c_CNT_W'(1) : '0);
        end
    end

`ifdef MOP_QUEUE_STATS_EN
    logic [c_CNT_W-1:0] r_max_occ;
    logic [31:0]        r_enq_stalls;

    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_max_occ    <= '0;
            r_enq_stalls <= '0;
        end else begin
            if (r_count > r_max_occ) begin
                r_max_occ <= r_count;
            end
            if (q.enq_valid && !w_enq_ready && !flush && (r_enq_stalls != '1)) begin
                r_enq_stalls <= r_enq_stalls + 32'd1;
            end
        end
    end

    assign stat_max_occ    = r_max_occ;
    assign stat_enq_stalls = r_enq_stalls;
`endif

    a_enq_count_legal: assert property (@(posedge clk) disable iff (!reset_n)
        q.enq_valid |-> (q.enq_count <= c_ECNT_W'(ENQ_WIDTH)));

    a_count_bounded: assert property (@(posedge clk) disable iff (!reset_n)
        r_count <= c_CNT_W'(DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_mop_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_mop_queue
// Brief    : Directed stimulus with a scoreboard-driven dequeue monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mop_queue;
    import mop_queue_pkg::*;

    localparam int DEPTH = 16;
    localparam int EW    = 3;

    logic clk = 1'b0;
    logic reset_n;
    logic flush;

    always #5 clk = ~clk;

    mop_queue_if #(.DEPTH(DEPTH), .ENQ_WIDTH(EW)) q ();

`ifdef MOP_QUEUE_STATS_EN
    logic [4:0]  stat_max_occ;
    logic [31:0] stat_enq_stalls;
`endif

    mop_queue #(.DEPTH(DEPTH), .ENQ_WIDTH(EW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .q       (q)
`ifdef MOP_QUEUE_STATS_EN
        ,
        .stat_max_occ    (stat_max_occ),
        .stat_enq_stalls (stat_enq_stalls)
`endif
    );

    int        n_checks = 0;
    int        n_fail   = 0;
    micro_op_t exp_q[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic micro_op_t mk(micro_opcode_t op, int s);
        micro_op_t m;
        m.opcode = op;
        m.dst    = 6'(s);
        m.src1   = 6'(s + 1);
        m.src2   = 6'(s + 2);
        m.imm    = 16'(s * 257);
        m.seq    = 8'(s);
        return m;
    endfunction

    // Monitor: every accepted pop must match the oldest expected micro-op.
    always @(negedge clk) begin
        if (reset_n && q.deq_valid && q.deq_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_deq: got %0h required no output", q.deq_mop);
            end else begin
                chk("deq_order", 64'(q.deq_mop), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_enq(int n, micro_op_t a, micro_op_t b, micro_op_t c, bit accept);
        q.enq_valid   = 1'b1;
        q.enq_count   = 2'(n);
        q.enq_mops[0] = a;
        q.enq_mops[1] = b;
        q.enq_mops[2] = c;
        if (accept) begin
            if (n > 0) exp_q.push_back(a);
            if (n > 1) exp_q.push_back(b);
            if (n > 2) exp_q.push_back(c);
        end
    endtask

    task automatic clr_enq();
        q.enq_valid = 1'b0;
        q.enq_count = '0;
        q.enq_mops  = '0;
    endtask

    task automatic idle_chk(string tag);
        chk({tag, "_occ"},       64'(q.occupancy), 64'd0);
        chk({tag, "_deq_valid"}, 64'(q.deq_valid), 64'd0);
        chk({tag, "_deq_mop"},   64'(q.deq_mop),   64'd0);
        chk({tag, "_enq_ready"}, 64'(q.enq_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        micro_op_t a0, a1, a2, a3, a4;
        reset_n     = 1'b0;
        flush       = 1'b0;
        q.deq_ready = 1'b0;
        clr_enq();
        #3;
        idle_chk("in_reset");
        #19 reset_n = 1'b1;

        // Idle after reset
        repeat (3) begin
            tick();
            idle_chk("idle");
        end

        // Cracked ld/add/st, then three ordered pops
        drive_enq(3, mk(M_LD, 1), mk(M_ADD, 2), mk(M_ST, 3), 1'b1);
        tick();
        clr_enq();
        chk("crack_occ", 64'(q.occupancy), 64'd3);
        chk("crack_valid", 64'(q.deq_valid), 64'd1);
        q.deq_ready = 1'b1;
        repeat (3) tick();
        q.deq_ready = 1'b0;
        chk("crack_drained_occ", 64'(q.occupancy), 64'd0);
        chk("crack_drained_valid", 64'(q.deq_valid), 64'd0);

        // Fill with singles until enq_ready drops, then wrap to full
        for (int i = 0; i < 14; i++) begin
            chk("fill_enq_ready", 64'(q.enq_ready), 64'd1);
            drive_enq(1, mk(M_ADD, 10 + i), '0, '0, 1'b1);
            tick();
            clr_enq();
        end
        chk("fill14_occ", 64'(q.occupancy), 64'd14);
        chk("fill14_enq_ready", 64'(q.enq_ready), 64'd0);
        drive_enq(3, mk(M_LD, 40), mk(M_SUB, 41), mk(M_ST, 42), 1'b0);
        q.deq_ready = 1'b1;
        tick();
        q.deq_ready = 1'b0;
        chk("stall_pop_occ", 64'(q.occupancy), 64'd13);
        chk("stall_pop_enq_ready", 64'(q.enq_ready), 64'd1);
        drive_enq(3, mk(M_LD, 40), mk(M_SUB, 41), mk(M_ST, 42), 1'b1);
        tick();
        clr_enq();
        chk("full_occ", 64'(q.occupancy), 64'd16);
        chk("full_enq_ready", 64'(q.enq_ready), 64'd0);
        q.deq_ready = 1'b1;
        repeat (16) tick();
        q.deq_ready = 1'b0;
        chk("wrap_drained_occ", 64'(q.occupancy), 64'd0);

        // enq_count = 0 is a no-op
        drive_enq(0, mk(M_ADD, 60), '0, '0, 1'b1);
        tick();
        clr_enq();
        chk("zero_cnt_occ", 64'(q.occupancy), 64'd0);
        chk("zero_cnt_valid", 64'(q.deq_valid), 64'd0);

        // Simultaneous 2-op enqueue and pop at occupancy 5
        a0 = mk(M_JCC, 50); a1 = mk(M_LD, 51); a2 = mk(M_ADD, 52);
        a3 = mk(M_SUB, 53); a4 = mk(M_ST, 54);
        drive_enq(3, a0, a1, a2, 1'b1);
        tick();
        drive_enq(2, a3, a4, '0, 1'b1);
        tick();
        clr_enq();
        chk("sim_occ5", 64'(q.occupancy), 64'd5);
        chk("sim_head_is_branch", 64'(mop_is_branch(q.deq_mop.opcode)), 64'd1);
        drive_enq(2, mk(M_ADD, 55), mk(M_ST, 56), '0, 1'b1);
        q.deq_ready = 1'b1;
        #1;
        chk("sim_no_bypass", 64'(q.deq_mop), 64'(a0));
        tick();
        clr_enq();
        q.deq_ready = 1'b0;
        chk("sim_occ6", 64'(q.occupancy), 64'd6);
        chk("sim_new_head", 64'(q.deq_mop), 64'(a1));
        q.deq_ready = 1'b1;
        repeat (6) tick();
        q.deq_ready = 1'b0;
        chk("sim_drained_occ", 64'(q.occupancy), 64'd0);

        // Flush at occupancy 7 with a concurrent 3-op enqueue
        drive_enq(3, mk(M_LD, 70), mk(M_ADD, 71), mk(M_ST, 72), 1'b1);
        tick();
        drive_enq(3, mk(M_LD, 73), mk(M_ADD, 74), mk(M_ST, 75), 1'b1);
        tick();
        drive_enq(1, mk(M_JMP, 76), '0, '0, 1'b1);
        tick();
        clr_enq();
        chk("pre_flush_occ", 64'(q.occupancy), 64'd7);
        flush = 1'b1;
        exp_q.delete();
        drive_enq(3, mk(M_LD, 80), mk(M_SUB, 81), mk(M_ST, 82), 1'b0);
        q.deq_ready = 1'b1;
        #1;
        chk("flush_deq_valid", 64'(q.deq_valid), 64'd0);
        tick();
        flush = 1'b0;
        clr_enq();
        idle_chk("post_flush");
        repeat (3) tick();
        drive_enq(1, mk(M_LD, 90), '0, '0, 1'b1);
        tick();
        clr_enq();
        chk("post_flush_enq_occ", 64'(q.occupancy), 64'd1);
        tick();
        q.deq_ready = 1'b0;
        chk("post_flush_pop_occ", 64'(q.occupancy), 64'd0);

        // Asynchronous reset mid-stream at occupancy 9
        for (int i = 0; i < 3; i++) begin
            drive_enq(3, mk(M_LD, 100 + 3 * i), mk(M_ADD, 101 + 3 * i), mk(M_ST, 102 + 3 * i), 1'b1);
            tick();
        end
        clr_enq();
        chk("pre_reset_occ", 64'(q.occupancy), 64'd9);
`ifdef MOP_QUEUE_STATS_EN
        chk("stat_max_occ", 64'(stat_max_occ), 64'd16);
        chk("stat_enq_stalls", 64'(stat_enq_stalls), 64'd1);
`endif
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        idle_chk("async_reset");
`ifdef MOP_QUEUE_STATS_EN
        chk("reset_stat_max_occ", 64'(stat_max_occ), 64'd0);
        chk("reset_stat_enq_stalls", 64'(stat_enq_stalls), 64'd0);
`endif
        #3 reset_n = 1'b1;
        tick();
        idle_chk("after_reset");

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
